// File: rtl/code_entry_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// code_entry_ctrl_pkg : key codes and controller state encoding shared with
//                       the keypad scanner.
// Revision : 1.0
// ============================================================================
package code_entry_ctrl_pkg;

  localparam logic [3:0] KEY_CLR = 4'hA;
  localparam logic [3:0] KEY_BS  = 4'hB;
  localparam logic [3:0] KEY_ENT = 4'hE;
  localparam logic [3:0] KEY_SET = 4'hF;

  localparam int NUM_DIGITS = 6;

  typedef enum logic [2:0] {
    ST_ENTRY     = 3'd0,
    ST_CHECK     = 3'd1,
    ST_OPEN      = 3'd2,
    ST_SET_ENTRY = 3'd3,
    ST_LOCKOUT   = 3'd4
  } state_e;

  function automatic logic is_digit(input logic [3:0] key);
    return key <= 4'd9;
  endfunction

endpackage
`default_nettype wire

// File: rtl/code_entry_ctrl_lockout_timer.sv
`default_nettype none
// ============================================================================
// lockout_timer : loadable down-counter; o_done is high in the last counted
//                 cycle so the owner sees exactly i_load_val busy cycles.
// Revision : 1.0
// ============================================================================
module lockout_timer #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic             o_done
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_done = (r_cnt == WIDTH'(1));

endmodule
`default_nettype wire

// File: rtl/code_entry_ctrl.sv
`default_nettype none
// ============================================================================
// code_entry_ctrl : keypad-side controller of the six-digit lock; collects
//                   digits, strobes the comparator and drives lock status.
// Optional failure lockout enabled by defining CODE_LOCKOUT_EN.
// Revision : 1.0
// ============================================================================
module code_entry_ctrl
  import code_entry_ctrl_pkg::*;
#(
  parameter logic [23:0] DEFAULT_CODE = 24'h123456,
  parameter int          MAX_FAIL     = 3,
  parameter int          LOCK_CYCLES  = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       c,
  output logic       s,
  output logic [3:0] a1,
  output logic [3:0] a2,
  output logic [3:0] a3,
  output logic [3:0] a4,
  output logic [3:0] a5,
  output logic [3:0] a6,
  output logic [3:0] b1,
  output logic [3:0] b2,
  output logic [3:0] b3,
  output logic [3:0] b4,
  output logic [3:0] b5,
  output logic [3:0] b6,
  output logic [2:0] digit_cnt,
  output logic       unlocked,
  output logic       fail,
  output logic       set_mode,
  output logic       locked_out
);

  state_e     r_state;
  logic [3:0] r_a [NUM_DIGITS];
  logic [3:0] r_b [NUM_DIGITS];
  logic [2:0] r_cnt;
  logic       r_s;
  logic       r_unlocked;
  logic       r_fail;
  logic       r_set_mode;

  logic w_digit;
  logic w_bs;
  logic w_clr;
  logic w_ent;
  logic w_set;
  logic w_full;

  assign w_digit = key_valid && is_digit(key_code);
  assign w_bs    = key_valid && (key_code == KEY_BS);
  assign w_clr   = key_valid && (key_code == KEY_CLR);
  assign w_ent   = key_valid && (key_code == KEY_ENT);
  assign w_set   = key_valid && (key_code == KEY_SET);
  assign w_full  = (r_cnt == 3'(NUM_DIGITS));

`ifdef CODE_LOCKOUT_EN
  localparam int FAIL_W = $clog2(MAX_FAIL + 1);
  localparam int TMR_W  = $clog2(LOCK_CYCLES + 1);
  localparam logic [FAIL_W-1:0] c_fail_limit  = FAIL_W'(MAX_FAIL);
  localparam logic [TMR_W-1:0]  c_lock_cycles = TMR_W'(LOCK_CYCLES);

  logic [FAIL_W-1:0] r_fail_cnt;
  logic [FAIL_W-1:0] w_fail_next;
  logic              w_lock_trip;
  logic              w_timer_done;
  logic              r_locked_out;

  assign w_fail_next = r_fail_cnt + 1'b1;
  assign w_lock_trip = (r_state == ST_CHECK) && !c && (w_fail_next >= c_fail_limit);
  assign locked_out  = r_locked_out;

  lockout_timer #(
    .WIDTH (TMR_W)
  ) u_lockout_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_lock_trip),
    .i_load_val (c_lock_cycles),
    .o_done     (w_timer_done)
  );
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^{MAX_FAIL[0], LOCK_CYCLES[0]};
  assign locked_out   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_ENTRY;
      r_cnt      <= '0;
      r_s        <= 1'b0;
      r_unlocked <= 1'b0;
      r_fail     <= 1'b0;
      r_set_mode <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        r_a[i] <= '0;
        r_b[i] <= DEFAULT_CODE[23-4*i -: 4];
      end
`ifdef CODE_LOCKOUT_EN
      r_fail_cnt   <= '0;
      r_locked_out <= 1'b0;
`endif
    end else begin
      r_s    <= 1'b0;
      r_fail <= 1'b0;
      case (r_state)
        // Editing keys behave identically while entering or setting a code.
        ST_ENTRY, ST_SET_ENTRY: begin
          if (w_digit) begin
            if (!w_full) begin
              r_a[r_cnt] <= key_code;
              r_cnt      <= r_cnt + 3'd1;
            end
          end else if (w_bs) begin
            if (r_cnt != 3'd0) begin
              r_a[r_cnt - 3'd1] <= '0;
              r_cnt             <= r_cnt - 3'd1;
            end
          end else if (w_clr) begin
            for (int i = 0; i < NUM_DIGITS; i++) r_a[i] <= '0;
            r_cnt <= '0;
            if (r_state == ST_SET_ENTRY && r_cnt == 3'd0) begin
              r_state    <= ST_OPEN;
              r_set_mode <= 1'b0;
            end
          end else if (w_ent) begin
            if (w_full && r_state == ST_ENTRY) begin
              r_state <= ST_CHECK;
              r_s     <= 1'b1;
            end else if (w_full) begin
              for (int i = 0; i < NUM_DIGITS; i++) begin
                r_b[i] <= r_a[i];
                r_a[i] <= '0;
              end
              r_cnt      <= '0;
              r_set_mode <= 1'b0;
              r_unlocked <= 1'b0;
              r_state    <= ST_ENTRY;
            end else begin
              r_fail <= 1'b1;
              if (r_state == ST_ENTRY) begin
                for (int i = 0; i < NUM_DIGITS; i++) r_a[i] <= '0;
                r_cnt <= '0;
              end
            end
          end
        end

        ST_CHECK: begin
          for (int i = 0; i < NUM_DIGITS; i++) r_a[i] <= '0;
          r_cnt <= '0;
          if (c) begin
            r_state    <= ST_OPEN;
            r_unlocked <= 1'b1;
`ifdef CODE_LOCKOUT_EN
            r_fail_cnt <= '0;
`endif
          end else begin
            r_fail  <= 1'b1;
            r_state <= ST_ENTRY;
`ifdef CODE_LOCKOUT_EN
            r_fail_cnt <= w_fail_next;
            if (w_lock_trip) begin
              r_state      <= ST_LOCKOUT;
              r_locked_out <= 1'b1;
            end
`endif
          end
        end

        ST_OPEN: begin
          if (w_clr) begin
            r_unlocked <= 1'b0;
            r_state    <= ST_ENTRY;
          end else if (w_set) begin
            r_set_mode <= 1'b1;
            r_state    <= ST_SET_ENTRY;
          end
        end

        ST_LOCKOUT: begin
`ifdef CODE_LOCKOUT_EN
          if (w_timer_done) begin
            r_locked_out <= 1'b0;
            r_fail_cnt   <= '0;
            r_state      <= ST_ENTRY;
          end
`else
          r_state <= ST_ENTRY;
`endif
        end

        default: r_state <= ST_ENTRY;
      endcase
    end
  end

  assign s         = r_s;
  assign unlocked  = r_unlocked;
  assign fail      = r_fail;
  assign set_mode  = r_set_mode;
  assign digit_cnt = r_cnt;
  assign a1 = r_a[0];
  assign a2 = r_a[1];
  assign a3 = r_a[2];
  assign a4 = r_a[3];
  assign a5 = r_a[4];
  assign a6 = r_a[5];
  assign b1 = r_b[0];
  assign b2 = r_b[1];
  assign b3 = r_b[2];
  assign b4 = r_b[3];
  assign b5 = r_b[4];
  assign b6 = r_b[5];

endmodule
`default_nettype wire

// File: tb/tb_code_entry_ctrl.sv
`default_nettype none
// ============================================================================
// tb_code_entry_ctrl : directed and random key sequences against a queue-based
//                      reference model of the lock, checked every cycle.
// Revision : 1.0
// ============================================================================
module tb_code_entry_ctrl;

  localparam logic [23:0] DEF_CODE = 24'h123456;
  localparam int          MAXF     = 3;
  localparam int          LOCKC    = 20;
`ifdef CODE_LOCKOUT_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  localparam int M_ENTRY = 0, M_CHECK = 1, M_OPEN = 2, M_SET = 3, M_LOCK = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_valid;
  logic [3:0] key_code;
  logic       c;
  logic       s;
  logic [3:0] a1, a2, a3, a4, a5, a6;
  logic [3:0] b1, b2, b3, b4, b5, b6;
  logic [2:0] digit_cnt;
  logic       unlocked, fail, set_mode, locked_out;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // Combinational comparator that normally lives in the parent.
  assign c = s & ({a1, a2, a3, a4, a5, a6} == {b1, b2, b3, b4, b5, b6});

  code_entry_ctrl #(
    .DEFAULT_CODE (DEF_CODE),
    .MAX_FAIL     (MAXF),
    .LOCK_CYCLES  (LOCKC)
  ) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code), .c(c), .s(s),
    .a1(a1), .a2(a2), .a3(a3), .a4(a4), .a5(a5), .a6(a6),
    .b1(b1), .b2(b2), .b3(b3), .b4(b4), .b5(b5), .b6(b6),
    .digit_cnt(digit_cnt), .unlocked(unlocked), .fail(fail),
    .set_mode(set_mode), .locked_out(locked_out)
  );

  // Reference model: entered digits as a queue, stored code as an array.
  int m_mode;
  int m_q[$];
  int m_b[6];
  bit m_s, m_unl, m_fail, m_set, m_lock;
  int m_fails, m_left;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit kv, input int k, input bit r);
    bit dig;
    bit match;
    dig = kv && (k <= 9);
    if (r) begin
      m_mode = M_ENTRY; m_q.delete();
      for (int i = 0; i < 6; i++) m_b[i] = (DEF_CODE >> (20 - 4*i)) & 4'hF;
      m_s = 0; m_unl = 0; m_fail = 0; m_set = 0; m_lock = 0; m_fails = 0; m_left = 0;
      return;
    end
    m_s = 0;
    m_fail = 0;
    case (m_mode)
      M_CHECK: begin
        match = 1;
        for (int i = 0; i < 6; i++) if (m_q[i] != m_b[i]) match = 0;
        m_q.delete();
        if (match) begin
          m_mode = M_OPEN; m_unl = 1; m_fails = 0;
        end else begin
          m_fail = 1;
          m_fails++;
          if (LOCK_EN && m_fails >= MAXF) begin
            m_mode = M_LOCK; m_left = LOCKC; m_lock = 1;
          end else begin
            m_mode = M_ENTRY;
          end
        end
      end
      M_ENTRY, M_SET: begin
        if (dig) begin
          if (m_q.size() < 6) m_q.push_back(k);
        end else if (kv && k == 'hB) begin
          if (m_q.size() > 0) void'(m_q.pop_back());
        end else if (kv && k == 'hA) begin
          if (m_mode == M_SET && m_q.size() == 0) begin
            m_mode = M_OPEN; m_set = 0;
          end
          m_q.delete();
        end else if (kv && k == 'hE) begin
          if (m_q.size() == 6 && m_mode == M_ENTRY) begin
            m_mode = M_CHECK; m_s = 1;
          end else if (m_q.size() == 6) begin
            for (int i = 0; i < 6; i++) m_b[i] = m_q[i];
            m_q.delete(); m_set = 0; m_unl = 0; m_mode = M_ENTRY;
          end else begin
            m_fail = 1;
            if (m_mode == M_ENTRY) m_q.delete();
          end
        end
      end
      M_OPEN: begin
        if (kv && k == 'hA) begin
          m_unl = 0; m_mode = M_ENTRY;
        end else if (kv && k == 'hF) begin
          m_set = 1; m_mode = M_SET;
        end
      end
      M_LOCK: begin
        m_left--;
        if (m_left == 0) begin
          m_lock = 0; m_fails = 0; m_mode = M_ENTRY;
        end
      end
      default: m_mode = M_ENTRY;
    endcase
  endtask

  task automatic compare_all();
    logic [23:0] ea;
    logic [23:0] eb;
    ea = '0;
    eb = '0;
    for (int i = 0; i < m_q.size(); i++) ea[23-4*i -: 4] = 4'(m_q[i]);
    for (int i = 0; i < 6; i++) eb[23-4*i -: 4] = 4'(m_b[i]);
    check_val("a",          32'({a1, a2, a3, a4, a5, a6}), 32'(ea));
    check_val("b",          32'({b1, b2, b3, b4, b5, b6}), 32'(eb));
    check_val("digit_cnt",  32'(digit_cnt),  32'(m_q.size()));
    check_val("s",          32'(s),          32'(m_s));
    check_val("unlocked",   32'(unlocked),   32'(m_unl));
    check_val("fail",       32'(fail),       32'(m_fail));
    check_val("set_mode",   32'(set_mode),   32'(m_set));
    check_val("locked_out", 32'(locked_out), 32'(m_lock));
  endtask

  task automatic cyc(input bit kv, input int k, input bit r);
    @(negedge clk);
    key_valid = kv;
    key_code  = 4'(k);
    rst       = r;
    @(posedge clk);
    model_step(kv, k, r);
    #1;
    compare_all();
  endtask

  task automatic press(input int k);
    cyc(1'b1, k, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 0, 1'b0);
  endtask

  task automatic enter_code(input logic [23:0] code);
    for (int i = 0; i < 6; i++) press(int'(code[23-4*i -: 4]));
    press('hE);
    idle(3);
  endtask

  initial begin
    rst = 1'b1; key_valid = 1'b0; key_code = '0;
    cyc(1'b0, 0, 1'b1);
    cyc(1'b1, 'h3, 1'b1);
    idle(2);

    enter_code(24'h123456);
    press('hA); idle(1);
    enter_code(24'h123457);
    press(9); press(8); press('hB); press(7); press('hA);
    for (int d = 1; d <= 7; d++) press(d);
    idle(1);
    press('hE); idle(3);

    enter_code(24'h123456);
    press('hF);
    enter_code(24'h654321);
    enter_code(24'h123456);
    enter_code(24'h654321);
    press('hA); idle(1);

    // short entries and set-mode abort
    press(1); press('hE); idle(1);
    enter_code(24'h654321);
    press('hF); press(4); press('hE); press('hA); press('hA); idle(1);
    press('hA); idle(1);

    enter_code(24'h000000);
    enter_code(24'h000000);
    enter_code(24'h000000);
    for (int d = 0; d < 8; d++) press(d);
    idle(LOCKC);
    enter_code(24'h654321);
    press('hA);

    press(1); press(2); press(3);
    cyc(1'b1, 5, 1'b1);
    idle(1);
    enter_code(24'h123456);
    press('hF); press(1); press(2);
    cyc(1'b0, 0, 1'b1);
    idle(1);

    for (int it = 0; it < 1500; it++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 2) begin
        cyc(1'b0, 0, 1'b1);
      end else if (r < 25) begin
        for (int i = 0; i < 6; i++) press(m_b[i]);
        press('hE);
        idle($urandom_range(0, 2));
      end else if (r < 35) begin
        for (int i = 0; i < 6; i++) press($urandom_range(0, 9));
        press('hE);
      end else if (r < 45) begin
        press('hF);
      end else if (r < 55) begin
        press('hA);
      end else if (r < 65) begin
        idle($urandom_range(1, 4));
      end else begin
        cyc(1'($urandom_range(0, 1)), $urandom_range(0, 15), 1'b0);
      end
    end
    idle(LOCKC + 5);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/code_entry_ctrl.md
# code_entry_ctrl

Sequential keypad-side controller for the six-digit electronic lock. Collects BCD key digits into the entered-code registers, holds the stored code, and strobes the combinational comparator's enable for one cycle. It samples the comparator result and drives unlock/fail status, password change and an optional failure lockout. It is the producer end of the comparator interface: it drives `s`, `a1..a6` and `b1..b6`, and it consumes `c`.

## Interface
- `DEFAULT_CODE`, 24'h123456: stored code after reset, six BCD nibbles, MSB nibble = b1.
- `MAX_FAIL`, 3: consecutive failures that trigger lockout (only with `CODE_LOCKOUT_EN`).
- `LOCK_CYCLES`, 1000: lockout duration in clk cycles (only with `CODE_LOCKOUT_EN`).
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `key_valid` input 1: one-cycle strobe; `key_code` is valid in that cycle.
- `key_code` input 4: 0–9 digit, 4'hA clear, 4'hB backspace, 4'hE enter, 4'hF set-code; others ignored.
- `c` input 1: comparator result, combinational from `s`/`a*`/`b*`.
- `s` output 1: comparator enable, high exactly one cycle per check.
- `a1..a6` output 4 each: entered digits, a1 = first key.
- `b1..b6` output 4 each: stored code.
- `digit_cnt` output 3: digits entered, 0–6.
- `unlocked` output 1: level, high after a successful check.
- `fail` output 1: one-cycle pulse on a failed check.
- `set_mode` output 1: high while a new code is being entered.
- `locked_out` output 1: high during lockout; constant 0 without the macro.

## Operation
- States: ENTRY, CHECK, OPEN, SET_ENTRY, LOCKOUT.
- ENTRY: a digit key with `digit_cnt`<6 writes `a[digit_cnt+1]` and increments the count. A digit at count 6 is ignored. Backspace at count>0 zeroes the last digit and decrements. Clear zeroes all `a*` and sets the count to 0. Enter at count 6 goes to CHECK. Enter at count<6 clears the entry and pulses `fail`; this is not counted as a lockout failure.
- CHECK: `s`=1 for one cycle and `c` is sampled in the same cycle.
  - `c`=1: go to OPEN, set `unlocked`, reset the fail counter.
  - `c`=0: pulse `fail` the next cycle, increment the fail counter, go to ENTRY, or to LOCKOUT if the counter reaches `MAX_FAIL`.
  - Both paths clear `a*` and `digit_cnt` on exit.
  - `key_valid` during CHECK is dropped.
- OPEN: clear → `unlocked`=0, go to ENTRY. Set-code → SET_ENTRY with `set_mode`=1 and `unlocked` held. Other keys are ignored.
- SET_ENTRY: same digit, backspace and clear editing as ENTRY. Enter at count 6 copies `a1..a6` into `b1..b6`, clears the entry, drops `set_mode` and `unlocked`, and goes to ENTRY. Enter at count<6 pulses `fail` and stays in SET_ENTRY. Clear at count 0 aborts back to OPEN.
- `s` is 0 in every state except CHECK. No digit is accepted outside ENTRY or SET_ENTRY.
- Reset in any state: state ENTRY, `a*`=0, `b*`=DEFAULT_CODE, `digit_cnt`=0. `s`, `unlocked`, `fail`, `set_mode` and `locked_out` are all 0, and the fail counter and lockout timer are 0. Reset has priority over `key_valid`.

## Timing
- Key effect is visible on `a*` and `digit_cnt` one cycle after the `key_valid` cycle.
- Enter (cycle N) → `s`=1 in N+1 → `unlocked` or `fail` in N+2.
- `b*` updates one cycle after the accepted set-code enter.
- All outputs are registered except `locked_out`, which is registered too; no output depends combinationally on inputs.
- Back-to-back `key_valid` every cycle is legal; each key is processed in order unless dropped by state.

## Configuration
- `CODE_LOCKOUT_EN` defined: fail counter and LOCKOUT state are present. LOCKOUT holds `locked_out`=1 for exactly `LOCK_CYCLES` cycles while ignoring all keys. It then returns to ENTRY with the counter cleared.
- Undefined: no counter and no timer. A failure always returns to ENTRY, `locked_out` is tied to 0, and `MAX_FAIL`/`LOCK_CYCLES` are unused.

## Structure
- Shared package: key code constants (`KEY_CLR`=4'hA, `KEY_BS`=4'hB, `KEY_ENT`=4'hE, `KEY_SET`=4'hF) and state encodings, reused by the keypad scanner.
- One sub-module, `lockout_timer`: load/count-down/done, instantiated only under `CODE_LOCKOUT_EN`.
- The comparator instance lives in the parent, which wires `s`, `a*`, `b*` and `c` between them.

## Test plan
- Reset, keys 1,2,3,4,5,6, enter, with the comparator matching → `s` pulses one cycle, `unlocked`=1 two cycles after enter, `b*` still 123456.
- Keys 1,2,3,4,5,7, enter → `fail` one-cycle pulse, `a*`=0, `digit_cnt`=0, `unlocked`=0.
- Keys 9,8, backspace, 7, clear, then seven digits 1–7 → `digit_cnt`=6 with `a*`=123456; the 7th digit is ignored.
- Unlock, set-code, keys 6,5,4,3,2,1, enter → `b*`=654321 and `set_mode`=0. Entering 123456 afterwards fails; entering 654321 unlocks.
- With `CODE_LOCKOUT_EN`, `LOCK_CYCLES`=20: three wrong codes → `locked_out`=1 for 20 cycles and keys are ignored. Afterwards the correct code unlocks.
- Assert `rst` mid-entry at `digit_cnt`=3 and also while in SET_ENTRY → all outputs return to reset values and `b*` returns to DEFAULT_CODE.
